// File: rtl/config_pkg.sv
// Shared configuration for the icache refill path: default geometry, derived sizes
// and the refill controller state encoding.
package config_pkg;

    localparam int unsigned ICACHE_PLEN             = 32;
    localparam int unsigned ICACHE_LINE_WIDTH       = 256;
    localparam int unsigned ICACHE_SET_ASSOC_WIDTH  = 2;
    localparam int unsigned ICACHE_INDEX_WIDTH      = 6;
    localparam int unsigned ICACHE_BUS_WIDTH        = 64;

    localparam int unsigned ICACHE_REFILL_BEATS      = ICACHE_LINE_WIDTH / ICACHE_BUS_WIDTH;
    localparam int unsigned ICACHE_LINE_OFFSET_WIDTH = $clog2(ICACHE_LINE_WIDTH / 8);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StData,
        StRefill
    } icache_refill_state_e;

endpackage

// File: rtl/icache_refill_ctrl.sv
// Icache line refill sequencer: one miss at a time, line-aligned burst read,
// beat assembly into a flat line buffer, then hand-off of line/way/address.
module icache_refill_ctrl
    import config_pkg::*;
#(
    parameter int unsigned PLEN        = ICACHE_PLEN,
    parameter int unsigned LINE_WIDTH  = ICACHE_LINE_WIDTH,
    parameter int unsigned WAY_WIDTH   = ICACHE_SET_ASSOC_WIDTH,
    parameter int unsigned INDEX_WIDTH = ICACHE_INDEX_WIDTH,
    parameter int unsigned BUS_WIDTH   = ICACHE_BUS_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,

    input  logic                   miss_req_valid_i,
    output logic                   miss_req_ready_o,
    input  logic [PLEN-1:0]        miss_req_paddr_i,
    input  logic [WAY_WIDTH-1:0]   miss_req_victim_way_i,
    input  logic [INDEX_WIDTH-1:0] miss_req_index_i,

    output logic                   refill_valid_o,
    input  logic                   refill_ready_i,
    output logic [PLEN-1:0]        refill_paddr_o,
    output logic [WAY_WIDTH-1:0]   refill_way_o,
    output logic [LINE_WIDTH-1:0]  refill_data_o,

    output logic                   mem_ar_valid_o,
    input  logic                   mem_ar_ready_i,
    output logic [PLEN-1:0]        mem_ar_addr_o,
    output logic [7:0]             mem_ar_len_o,

    input  logic                   mem_r_valid_i,
    output logic                   mem_r_ready_o,
    input  logic [BUS_WIDTH-1:0]   mem_r_data_i,
    input  logic                   mem_r_last_i,

    output logic                   protocol_err_o
);

    localparam int unsigned Beats  = LINE_WIDTH / BUS_WIDTH;
    localparam int unsigned CntW   = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int unsigned Offset = $clog2(LINE_WIDTH / 8);

    icache_refill_state_e   state_q, state_d;
    logic [LINE_WIDTH-1:0]  line_q, line_d;
    logic [PLEN-1:0]        paddr_q, paddr_d;
    logic [WAY_WIDTH-1:0]   way_q, way_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   final_beat;

    // The index travels with the miss but has no return port in this slice.
    logic unused_index;
    assign unused_index = ^index_q;

    assign final_beat = (cnt_q == CntW'(Beats - 1));

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        paddr_d = paddr_q;
        way_d   = way_q;
        index_d = index_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (miss_req_valid_i) begin
                    paddr_d              = miss_req_paddr_i;
                    paddr_d[Offset-1:0]  = '0;
                    way_d                = miss_req_victim_way_i;
                    index_d              = miss_req_index_i;
                    cnt_d                = '0;
                    state_d              = StReq;
                end
            end
            StReq: begin
                if (mem_ar_ready_i) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (mem_r_valid_i) begin
                    line_d[cnt_q*BUS_WIDTH +: BUS_WIDTH] = mem_r_data_i;
                    cnt_d = cnt_q + 1'b1;
                    // r_last is only checked; the counter alone decides completion.
                    err_d = (mem_r_last_i != final_beat);
                    if (final_beat) begin
                        state_d = StRefill;
                    end
                end
            end
            StRefill: begin
                if (refill_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            line_q  <= '0;
            paddr_q <= '0;
            way_q   <= '0;
            index_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            paddr_q <= paddr_d;
            way_q   <= way_d;
            index_q <= index_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        miss_req_ready_o = (state_q == StIdle);
        mem_ar_valid_o   = (state_q == StReq);
        mem_r_ready_o    = (state_q == StData);
        refill_valid_o   = (state_q == StRefill);
        mem_ar_addr_o    = mem_ar_valid_o ? paddr_q : '0;
        mem_ar_len_o     = mem_ar_valid_o ? 8'(Beats - 1) : 8'd0;
        refill_paddr_o   = refill_valid_o ? paddr_q : '0;
        refill_way_o     = refill_valid_o ? way_q : '0;
        refill_data_o    = refill_valid_o ? line_q : '0;
        protocol_err_o   = err_q;
    end

endmodule
